// File: rtl/cell_luma_quantizer.sv
// Averages CELL_W x CELL_H luma cells and quantizes each to a 0..47 glyph index.
// Build option: CELL_LUMA_INVERT_EN selects dark-on-light indexing (47 - id).
module cell_luma_quantizer #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CELL_W   = 8,
   parameter int CELL_H   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 pix_valid,
   input  logic [7:0]                           pix_luma,
   input  logic                                 pix_sof,
   output logic                                 id_valid,
   output logic [5:0]                           id,
   output logic [$clog2(H_ACTIVE/CELL_W)-1:0]   cell_x,
   output logic [$clog2(V_ACTIVE/CELL_H)-1:0]   cell_y,
   output logic                                 frame_done
);

   localparam int NCX   = H_ACTIVE / CELL_W;
   localparam int NCY   = V_ACTIVE / CELL_H;
   localparam int CXW   = $clog2(NCX);
   localparam int CYW   = $clog2(NCY);
   localparam int LXW   = $clog2(CELL_W);
   localparam int LYW   = $clog2(CELL_H);
   localparam int SH    = $clog2(CELL_W * CELL_H);
   localparam int SUM_W = 8 + SH;
   localparam int PXW   = $clog2(H_ACTIVE);
   localparam int PYW   = $clog2(V_ACTIVE);

   localparam logic [PXW-1:0] PX_LAST = PXW'(H_ACTIVE - 1);
   localparam logic [PYW-1:0] PY_LAST = PYW'(V_ACTIVE - 1);
   localparam logic [CXW-1:0] CX_LAST = CXW'(NCX - 1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(NCY - 1);

   generate
      if ((1 << SH) != CELL_W * CELL_H || SH > 8)
         $error("CELL_W*CELL_H must be a power of two <= 256");
      if (H_ACTIVE % CELL_W != 0 || V_ACTIVE % CELL_H != 0)
         $error("active size must be a multiple of the cell size");
      if (CELL_W < 2 || CELL_H < 2 || NCX < 2 || NCY < 2)
         $error("cell grid must be at least 2x2 with cells of 2x2");
   endgenerate

   logic [PXW-1:0]   px, ex, px_nxt;
   logic [PYW-1:0]   py, ey, py_nxt;
   logic [LXW-1:0]   lx;
   logic [LYW-1:0]   ly;
   logic [CXW-1:0]   cx;
   logic [CYW-1:0]   cy;
   logic             fresh;
   logic             cell_end;
   logic             frame_end;
   logic [SUM_W-1:0] acc [NCX];
   logic [SUM_W-1:0] base;
   logic [SUM_W-1:0] sum;
   logic [7:0]       avg;
   logic [13:0]      prod;
   logic [5:0]       qid;
   logic [5:0]       id_nxt;

   // A start-of-frame pixel overrides the running count.
   always_comb begin
      ex = pix_sof ? '0 : px;
      ey = pix_sof ? '0 : py;
   end

   assign lx = ex[LXW-1:0];
   assign cx = ex[PXW-1:LXW];
   assign ly = ey[LYW-1:0];
   assign cy = ey[PYW-1:LYW];

   assign fresh     = (lx == '0) && (ly == '0);
   assign cell_end  = (&lx) && (&ly);
   assign frame_end = cell_end && (cx == CX_LAST) && (cy == CY_LAST);

   always_comb begin
      px_nxt = ex + PXW'(1);
      py_nxt = ey;
      if (ex == PX_LAST) begin
         px_nxt = '0;
         py_nxt = (ey == PY_LAST) ? '0 : ey + PYW'(1);
      end
   end

   always_comb begin
      base = fresh ? '0 : acc[cx];
      sum  = base + SUM_W'(pix_luma);
      avg  = 8'(sum >> SH);
      prod = {6'd0, avg} * 14'd48;
      qid  = 6'(prod >> 8);
   end

`ifdef CELL_LUMA_INVERT_EN
   assign id_nxt = 6'd47 - qid;
`else
   assign id_nxt = qid;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px <= '0;
         py <= '0;
      end else if (pix_valid) begin
         px <= px_nxt;
         py <= py_nxt;
      end
   end

   // Accumulator contents need no reset: every cell starts fresh.
   always_ff @(posedge clk) begin
      if (pix_valid)
         acc[cx] <= sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid   <= 1'b0;
         id         <= '0;
         cell_x     <= '0;
         cell_y     <= '0;
         frame_done <= 1'b0;
      end else begin
         id_valid   <= pix_valid && cell_end;
         frame_done <= pix_valid && frame_end;
         if (pix_valid && cell_end) begin
            id     <= id_nxt;
            cell_x <= cx;
            cell_y <= cy;
         end
      end
   end

endmodule

// File: tb/tb_cell_luma_quantizer.sv
// Randomized bench for cell_luma_quantizer on a 32x32 frame of 8x16 cells.
// Behavioural frame-buffer model plus literal id expectations per scenario.
module tb_cell_luma_quantizer;

   localparam int H  = 32;
   localparam int V  = 32;
   localparam int CW = 8;
   localparam int CH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_valid;
   logic [7:0] pix_luma;
   logic       pix_sof;
   logic       id_valid;
   logic [5:0] id;
   logic [1:0] cell_x;
   logic [0:0] cell_y;
   logic       frame_done;

   cell_luma_quantizer #(
      .H_ACTIVE(H), .V_ACTIVE(V), .CELL_W(CW), .CELL_H(CH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_valid(pix_valid), .pix_luma(pix_luma), .pix_sof(pix_sof),
      .id_valid(id_valid), .id(id),
      .cell_x(cell_x), .cell_y(cell_y),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int cx;
      int cy;
      bit fd;
   } exp_t;

   exp_t expq[$];
   int   pixbuf[V][H];
   int   mx, my;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses = 0;
   int   fds = 0;
   int   p0 = 0;
   int   f0 = 0;
   int   lit_mode = 0;
   int   lit_val = 0;
   int   last_id = 0;
   int   last_cx = 0;
   int   last_cy = 0;

   function automatic void chk(string nm, int act, int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", nm, act, want, $time);
      end
   endfunction

   function automatic int adj(int v);
`ifdef CELL_LUMA_INVERT_EN
      return 47 - v;
`else
      return v;
`endif
   endfunction

   // Model: store the frame, recompute the whole cell mean on its last pixel.
   function automatic void model_pix(int l, bit s);
      exp_t e;
      int   sum;
      if (s) begin
         mx = 0;
         my = 0;
      end
      pixbuf[my][mx] = l;
      if (mx % CW == CW - 1 && my % CH == CH - 1) begin
         sum = 0;
         for (int y = my - CH + 1; y <= my; y++)
            for (int x = mx - CW + 1; x <= mx; x++)
               sum += pixbuf[y][x];
         e.id = adj(((sum / (CW * CH)) * 48) / 256);
         e.cx = mx / CW;
         e.cy = my / CH;
         e.fd = (mx == H - 1) && (my == V - 1);
         expq.push_back(e);
      end
      mx++;
      if (mx == H) begin
         mx = 0;
         my = (my == V - 1) ? 0 : my + 1;
      end
   endfunction

   function automatic void model_reset();
      expq.delete();
      mx = 0;
      my = 0;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (id_valid) begin
            exp_t e;
            pulses++;
            if (frame_done)
               fds++;
            if (expq.size() == 0) begin
               chk("unexpected_id_valid", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("id", int'(id), e.id);
               chk("cell_x", int'(cell_x), e.cx);
               chk("cell_y", int'(cell_y), e.cy);
               chk("frame_done", int'(frame_done), int'(e.fd));
               last_id = e.id;
               last_cx = e.cx;
               last_cy = e.cy;
            end
            if (lit_mode == 1)
               chk("lit_const_id", int'(id), adj(lit_val));
            else if (lit_mode == 2)
               chk("lit_col_id", int'(id), adj(12 * int'(cell_x)));
         end else begin
            chk("fd_idle", int'(frame_done), 0);
            chk("id_hold", int'(id), last_id);
            chk("cx_hold", int'(cell_x), last_cx);
            chk("cy_hold", int'(cell_y), last_cy);
         end
      end
   end

   task automatic drive(input bit v, input int l, input bit s);
      @(posedge clk);
      #1;
      pix_valid = v;
      pix_luma  = 8'(l);
      pix_sof   = s;
      if (v)
         model_pix(l, s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 0, 1'b0);
   endtask

   // mode 0: constant, 1: 64*column, 2: random. gap 3: every 3rd cycle, -1: random.
   task automatic frame(input int mode, input int val, input int gap, input bit sof);
      int c;
      int l;
      c = 0;
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            if ((gap == 3 && c % 3 == 2) || (gap < 0 && $urandom_range(0, 3) == 0)) begin
               idle(1);
               c++;
            end
            case (mode)
               0:       l = val;
               1:       l = 64 * (x / CW);
               default: l = int'($urandom_range(0, 255));
            endcase
            drive(1'b1, l, sof && x == 0 && y == 0);
            c++;
         end
      end
   endtask

   task automatic settle(input string nm, input int np, input int nf);
      idle(3);
      chk({nm, "_pulses"}, pulses - p0, np);
      chk({nm, "_frames"}, fds - f0, nf);
      chk({nm, "_queue_left"}, expq.size(), 0);
      p0 = pulses;
      f0 = fds;
      lit_mode = 0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_id_valid"}, int'(id_valid), 0);
      chk({nm, "_id"}, int'(id), 0);
      chk({nm, "_cell_x"}, int'(cell_x), 0);
      chk({nm, "_cell_y"}, int'(cell_y), 0);
      chk({nm, "_frame_done"}, int'(frame_done), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      pix_luma  = '0;
      pix_sof   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      lit_mode = 1; lit_val = 0;
      frame(0, 0, 0, 1'b1);
      settle("luma0", 8, 1);

      lit_mode = 1; lit_val = 47;
      frame(0, 255, 0, 1'b0);
      settle("luma255", 8, 1);

      lit_mode = 1; lit_val = 24;
      frame(0, 128, 0, 1'b1);
      settle("luma128", 8, 1);

      lit_mode = 2;
      frame(1, 0, 0, 1'b1);
      settle("cols", 8, 1);

      lit_mode = 2;
      frame(1, 0, 3, 1'b1);
      settle("cols_gap", 8, 1);

      for (int i = 0; i < 200; i++)
         drive(1'b1, int'($urandom_range(0, 255)), 1'b0);
      lit_mode = 1; lit_val = 47;
      frame(0, 255, 0, 1'b1);
      settle("resync", 8, 1);

      for (int i = 0; i < 100; i++)
         drive(1'b1, 255, 1'b0);
      idle(2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      last_id = 0;
      last_cx = 0;
      last_cy = 0;
      p0 = pulses;
      f0 = fds;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lit_mode = 1; lit_val = 24;
      frame(0, 128, 0, 1'b0);
      settle("after_rst", 8, 1);

      lit_mode = 1; lit_val = 24;
      frame(0, 128, 0, 1'b0);
      frame(0, 128, 0, 1'b0);
      settle("b2b", 16, 2);

      frame(2, 0, -1, 1'b0);
      frame(2, 0, 0, 1'b1);
      frame(2, 0, -1, 1'b0);
      settle("random", 24, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end

endmodule
